dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Two-master arbiter that shares the single data memory (dm) between the pipeline CPU load/store port (master 0) and a secondary requester (master 1), such as a debug/DMA loader.
- Fixed priority to the CPU, with a starvation counter that forces a master-1 grant after a bounded wait.
- Drives the dm write/address/data/type inputs.
- Returns registered read data with a per-master valid strobe.
- Sits between cpu, the secondary master and dm in the top-level comp.

Parameters:
STARVE_LIMIT, 4, consecutive cycles master 1 may wait before forced grant (0 = master 1 strict priority)
CNT_W, $clog2(STARVE_LIMIT+1) (min 1), starvation counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  CPU access request
m0_we  input  1  CPU write (1) / read (0)
m0_addr  input  32  CPU byte address
m0_wdata  input  32  CPU write data
m0_type  input  3  CPU DMType
m0_gnt  output  1  CPU access accepted this cycle (low = CPU stalls)
m0_rvalid  output  1  CPU read data valid
m0_rdata  output  32  CPU read data
m1_req, m1_we, m1_addr, m1_wdata, m1_type  input  1/1/32/32/3  master-1 request fields, same meaning
m1_gnt  output  1  master-1 access accepted
m1_rvalid  output  1  master-1 read data valid
m1_rdata  output  32  master-1 read data
dm_we  output  1  to dm DMWr
dm_addr  output  32  to dm addr
dm_din  output  32  to dm din
dm_type  output  3  to dm DMType
dm_dout  input  32  from dm dout (combinational read)

Behaviour:
Reset (asynchronous, active-high):
- Starvation counter, m0_rvalid, m1_rvalid, m0_rdata and m1_rdata clear to 0.
- While reset is high, m0_gnt, m1_gnt and dm_we are forced to 0.

Grant (combinational, same cycle as request; at most one grant per cycle):
- If m1_req and cnt == STARVE_LIMIT: grant m1.
- Else if m0_req: grant m0.
- Else if m1_req: grant m1.
- Else: no grant.

Requester rules:
- A requester holds req and all its fields stable until it sees gnt high.
- The access completes at the rising edge where gnt is high.
- A master may issue back-to-back requests with no gap.

Memory-side mux:
- dm_* takes the granted master's fields.
- With no grant: dm_we=0, dm_addr=0, dm_din=0, dm_type=0. A non-granted master can never write.

Starvation counter (registered):
- Increments by 1 when m1_req && !m1_gnt.
- Saturates at STARVE_LIMIT.
- Clears to 0 when m1_gnt or !m1_req.

Read return:
- m0_rvalid <= m0_gnt & ~m0_we.
- m0_rdata <= dm_dout when that condition holds; otherwise holds its previous value.
- Master 1 behaves the same way.
- Read latency is 1 cycle after the granted edge.
- rvalid is a single-cycle pulse per read; back-to-back reads give consecutive pulses.
- Writes produce no rvalid.

Boundary conditions:
- Simultaneous m0/m1 requests with cnt < STARVE_LIMIT: m0 wins. With cnt == STARVE_LIMIT: m1 wins, and m0_gnt stays low that cycle.
- STARVE_LIMIT=0: m1 always wins when requesting.
- Reset asserted mid-access: the pending rvalid is dropped, and no write reaches dm while reset is high.
- Addresses and types pass through unmodified; alignment is dm's responsibility.

Test Plan:
- Reset: assert reset with both reqs high -> m0_gnt=m1_gnt=0, dm_we=0, both rvalid=0. Deassert -> m0_gnt=1 in the first cycle.
- CPU alone: m0 write 0x12345678 to 0x10 (type word), then read 0x10 -> gnt high both cycles; m0_rvalid=1 with m0_rdata=0x12345678 one cycle after the read; m1_rvalid stays 0.
- Contention, STARVE_LIMIT=4: m0_req and m1_req held high from cycle 0 -> m0 granted cycles 0-3, m1 granted cycle 4, m0 cycles 5-8, m1 cycle 9. Counter reads 0,1,2,3,4,0 at cycles 0-5.
- Counter clear: m1_req high for 2 blocked cycles, then low 1 cycle, then high -> counter returns to 0 and m1 waits a further 4 cycles before its forced grant.
- Master-1 read: m1 reads 0x20 (preloaded 0xCAFEBABE) while m0 idle -> m1_gnt same cycle; m1_rvalid=1 with m1_rdata=0xCAFEBABE next cycle; m0_rdata unchanged.
- Reset mid-read: assert reset in the cycle after an m0 read grant -> m0_rvalid=0 and m0_rdata=0 immediately; no dm write occurs while reset is high.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master data-memory arbiter: fixed CPU priority with a starvation-forced grant for master 1.
// Grant is combinational in the request cycle; read data returns registered one cycle later; losers stall on gnt low.
module dm_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_type,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_type,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [2:0]  dm_type,
    input  logic [31:0] dm_dout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m0_rvalid_q, m0_rvalid_d;
    logic             m1_rvalid_q, m1_rvalid_d;
    logic [31:0]      m0_rdata_q, m0_rdata_d;
    logic [31:0]      m1_rdata_q, m1_rdata_d;
    logic             gnt0, gnt1;

    // Grants are gated by reset so nothing reaches dm while the block is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (m1_req && (cnt_q == LIMIT)) begin
                gnt1 = 1'b1;
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        dm_we   = 1'b0;
        dm_addr = 32'd0;
        dm_din  = 32'd0;
        dm_type = 3'd0;
        if (gnt0) begin
            dm_we   = m0_we;
            dm_addr = m0_addr;
            dm_din  = m0_wdata;
            dm_type = m0_type;
        end else if (gnt1) begin
            dm_we   = m1_we;
            dm_addr = m1_addr;
            dm_din  = m1_wdata;
            dm_type = m1_type;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!m1_req || gnt1) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        m0_rvalid_d = gnt0 & ~m0_we;
        m1_rvalid_d = gnt1 & ~m1_we;
        m0_rdata_d  = m0_rvalid_d ? dm_dout : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? dm_dout : m1_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed stimulus feeds per-master expected-read queues; a negedge monitor checks returns.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;

    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [2:0]  m0_type = '0;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [2:0]  m1_type = '0;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;

    logic        dm_we;
    logic [31:0] dm_addr, dm_din, dm_dout;
    logic [2:0]  dm_type;

    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_type(m0_type),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_type(m1_type),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type), .dm_dout(dm_dout)
    );

    // Word-addressed memory with combinational read, like dm.
    always @(posedge clk) begin
        if (preload) begin
            mem[8]  <= 32'hCAFEBABE;
            mem[16] <= 32'h11112222;
        end else if (dm_we) begin
            mem[dm_addr[7:2]] <= dm_din;
        end
    end
    assign dm_dout = mem[dm_addr[7:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (m0_rvalid) begin
            if (q0.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL m0_rvalid_unexpected: got 1 expected 0");
            end else begin
                chk("m0_rdata", m0_rdata, q0.pop_front());
            end
        end
        if (m1_rvalid) begin
            if (q1.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL m1_rvalid_unexpected: got 1 expected 0");
            end else begin
                chk("m1_rdata", m1_rdata, q1.pop_front());
            end
        end
    end

    logic [0:17] m1v;
    logic [0:17] g1v;

    initial begin
        // Reset with both masters requesting: m0 write to 0x30, m1 read of 0x20.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h30; m0_wdata = 32'hA5A50001; m0_type = 3'd2;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_type = 3'd2;
        #2;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        @(negedge clk);
        chk("rst_dm_we_held", dm_we, 0);
        tick(); tick();
        reset = 1'b0; preload = 1'b0;
        @(negedge clk);
        chk("post_rst_m0_gnt", m0_gnt, 1);
        chk("post_rst_m1_gnt", m1_gnt, 0);
        chk("post_rst_dm_we", dm_we, 1);
        chk("post_rst_dm_addr", dm_addr, 32'h30);
        chk("post_rst_dm_din", dm_din, 32'hA5A50001);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("m1_read_gnt", m1_gnt, 1);
        chk("m1_read_m0_gnt", m0_gnt, 0);
        chk("m1_read_dm_addr", dm_addr, 32'h20);
        q1.push_back(32'hCAFEBABE);
        tick();
        m1_req = 1'b0;

        // CPU alone: write then read back 0x10.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h12345678; m0_type = 3'd2;
        @(negedge clk);
        chk("cpu_wr_gnt", m0_gnt, 1);
        chk("cpu_wr_dm_we", dm_we, 1);
        chk("cpu_wr_dm_din", dm_din, 32'h12345678);
        chk("cpu_wr_dm_type", dm_type, 3'd2);
        tick();
        m0_we = 1'b0;
        @(negedge clk);
        chk("cpu_rd_gnt", m0_gnt, 1);
        chk("cpu_rd_dm_we", dm_we, 0);
        q0.push_back(32'h12345678);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("cpu_rd_m1_rdata_kept", m1_rdata, 32'hCAFEBABE);
        chk("cpu_rd_m1_rvalid", m1_rvalid, 0);
        tick();

        // Contention (cycles 0-9), then counter clear on a one-cycle m1 drop (cycles 10-17).
        m1v = 18'b11111111_11_11011111;
        g1v = 18'b00001000_01_00000001;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_we = 1'b0; m1_addr = 32'h20;
        for (int c = 0; c < 18; c++) begin
            m1_req = m1v[c];
            @(negedge clk);
            chk($sformatf("cont_m1_gnt_c%0d", c), m1_gnt, g1v[c]);
            chk($sformatf("cont_m0_gnt_c%0d", c), m0_gnt, !g1v[c]);
            if (g1v[c]) begin
                chk($sformatf("cont_dm_addr_c%0d", c), dm_addr, 32'h20);
                q1.push_back(32'hCAFEBABE);
            end else begin
                q0.push_back(32'h12345678);
            end
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        tick();

        // Reset mid-read: read granted, reset asserted in the cycle its rvalid would show.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        @(negedge clk);
        chk("midrst_rd_gnt", m0_gnt, 1);
        tick();
        m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h99999999;
        reset = 1'b1;
        #1;
        chk("midrst_m0_rvalid", m0_rvalid, 0);
        chk("midrst_m0_rdata", m0_rdata, 0);
        chk("midrst_m1_rdata", m1_rdata, 0);
        chk("midrst_m0_gnt", m0_gnt, 0);
        chk("midrst_dm_we", dm_we, 0);
        @(negedge clk);
        chk("midrst_dm_we_neg", dm_we, 0);
        tick();
        m0_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        @(negedge clk);
        chk("postrst_rd_gnt", m0_gnt, 1);
        q0.push_back(32'h11112222);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        tick();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
